// File: rtl/mxint_block_quantizer.sv
// rtl/mxint_block_quantizer.sv - streaming float32 to MXINT block quantizer; MXINT_SAT_FLAG_EN adds o_saturated
module mxint_block_quantizer #(
    parameter int BLOCK_SIZE = 32,
    parameter int ELEM_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [31:0]           i_float32,
    input  logic                  i_valid,
    output logic                  o_in_ready,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [7:0]            o_scale,
    output logic [ELEM_WIDTH-1:0] o_element,
`ifdef MXINT_SAT_FLAG_EN
    output logic                  o_saturated,
`endif
    output logic                  o_last
);

    localparam int IDX_W = $clog2(BLOCK_SIZE);
    localparam int FRAC  = ELEM_WIDTH - 2;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
    localparam logic [ELEM_WIDTH-1:0] MAX_CODE = {1'b0, {(ELEM_WIDTH-1){1'b1}}};
    localparam logic [9:0]            BASE_SHIFT = 10'(23 - FRAC);

    typedef enum logic {
        COLLECT,
        EMIT
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      mem [BLOCK_SIZE];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       max_exp;
    logic             nan_seen;

    logic             in_fire;
    logic             out_fire;
    logic [7:0]       in_exp;

    assign in_exp   = i_float32[30:23];
    assign in_fire  = i_valid && o_in_ready;
    assign out_fire = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        o_in_ready = 1'b0;
        o_valid    = 1'b0;
        case (state)
            COLLECT: begin
                o_in_ready = 1'b1;
                if (i_valid && (wr_idx == LAST_IDX)) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                o_valid = 1'b1;
                if (i_ready && (rd_idx == LAST_IDX)) begin
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Indices are power-of-two wide, so the final increment wraps them to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            max_exp  <= 8'd0;
            nan_seen <= 1'b0;
        end else begin
            if (in_fire) begin
                wr_idx <= wr_idx + 1'b1;
                if (in_exp == 8'hFF) begin
                    nan_seen <= 1'b1;
                end else if ((in_exp != 8'd0) && (in_exp > max_exp)) begin
                    max_exp <= in_exp;
                end
            end
            if (out_fire) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_idx == LAST_IDX) begin
                    max_exp  <= 8'd0;
                    nan_seen <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (in_fire && !i_rst) begin
            mem[wr_idx] <= i_float32;
        end
    end

    logic [31:0]           cur;
    logic                  cur_sign;
    logic [7:0]            cur_exp;
    logic [23:0]           sig;
    logic [7:0]            exp_diff;
    logic [9:0]            shift;
    logic [23:0]           trunc;
    logic                  guard;
    logic                  sticky;
    logic [24:0]           rounded;
    logic [ELEM_WIDTH-1:0] mag;
    logic                  sat;
    logic [ELEM_WIDTH-1:0] elem;

    assign cur      = mem[rd_idx];
    assign cur_sign = cur[31];
    assign cur_exp  = cur[30:23];
    assign sig      = {1'b1, cur[22:0]};

    // Round-to-nearest-even of sig scaled down to FRAC fraction bits against max_exp.
    always_comb begin
        exp_diff = max_exp - cur_exp;
        shift    = BASE_SHIFT + {2'b00, exp_diff};
        trunc    = 24'd0;
        guard    = 1'b0;
        sticky   = 1'b0;
        rounded  = 25'd0;
        mag      = '0;
        sat      = 1'b0;
        elem     = '0;
        if (!nan_seen && (cur_exp != 8'd0)) begin
            if (shift < 10'd25) begin
                trunc   = sig >> shift;
                guard   = |(sig & (24'd1 << (shift - 10'd1)));
                sticky  = |(sig & ((24'd1 << (shift - 10'd1)) - 24'd1));
                rounded = {1'b0, trunc} + {24'd0, guard & (sticky | trunc[0])};
            end
            if (rounded > {{(25-ELEM_WIDTH){1'b0}}, MAX_CODE}) begin
                mag = MAX_CODE;
                sat = 1'b1;
            end else begin
                mag = rounded[ELEM_WIDTH-1:0];
            end
            elem = cur_sign ? -mag : mag;
        end
    end

    always_comb begin
        o_scale   = 8'd0;
        o_element = '0;
        o_last    = 1'b0;
        if (state == EMIT) begin
            o_scale   = nan_seen ? 8'hFF : max_exp;
            o_element = elem;
            o_last    = (rd_idx == LAST_IDX);
        end
    end

`ifdef MXINT_SAT_FLAG_EN
    assign o_saturated = (state == EMIT) && sat;
`endif

endmodule

// File: doc/mxint_block_quantizer.md
Name: mxint_block_quantizer

Overview:
Streaming float32-to-MXINT quantizer for a full MX block, parametrised in element width and block size.
- Accepts BLOCK_SIZE float32 values serially and buffers them.
- Computes one true shared scale, the maximum biased exponent across the block.
- Emits the scale plus BLOCK_SIZE two's-complement MXINT elements serially.
- Sits between the float32 producer and the MX ALU operand loaders.
- Supersedes the single-value broadcast converter.

Parameters:
BLOCK_SIZE, 32, elements per MX block (power of two, 2..64)
ELEM_WIDTH, 8, MXINT element width in bits (4..16); F = ELEM_WIDTH-2 fraction bits, 1 integer bit, 1 sign bit

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_float32  input  32  input element (IEEE-754 binary32)
i_valid  input  1  input element valid
o_in_ready  output  1  block can accept an input element
o_valid  output  1  output beat valid
i_ready  input  1  downstream accepts output beat
o_scale  output  8  shared E8M0 scale (bias 127); constant for all beats of a block
o_element  output  ELEM_WIDTH  quantized element, two's complement
o_last  output  1  high on the final beat (element BLOCK_SIZE-1)

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
  - Reset values: state=COLLECT, wr_idx=0, rd_idx=0, max_exp=0, nan_seen=0.
  - Reset outputs: o_in_ready=1, o_valid=0, o_scale=0, o_element=0, o_last=0.
  - Reset mid-block discards all buffered or partially emitted data.
- State COLLECT:
  - o_in_ready=1, o_valid=0.
  - On i_valid&&o_in_ready: store i_float32 at buf[wr_idx] and increment wr_idx.
  - Update max_exp=max(max_exp, exp field) for exp in 1..254.
  - exp==255 (Inf/NaN) sets nan_seen.
  - exp==0 (zero/subnormal) does not affect max_exp.
  - When the BLOCK_SIZE-th element is accepted: wr_idx wraps to 0, next state EMIT.
- State EMIT:
  - o_in_ready=0, o_valid=1.
  - o_element is the conversion of buf[rd_idx]; o_last=(rd_idx==BLOCK_SIZE-1).
  - On i_ready, rd_idx increments.
  - On the last-beat handshake: rd_idx=0, max_exp=0, nan_seen=0, next state COLLECT. o_in_ready=1 in the following cycle.
  - With i_ready low, all outputs hold stable.
- Latency: first output beat is valid the cycle after the last input is accepted.
- Throughput: one block per 2*BLOCK_SIZE cycles with no stalls.
- Scale: o_scale = 255 if nan_seen, else max_exp. An all-zero block gives scale 0.
- Element conversion, for element x with sign s, exp e, mantissa m:
  - nan_seen: element = 0.
  - e==0: element = 0.
  - Otherwise: d = max_exp - e, sig = {1,m} (24 bits).
  - mag = RNE(sig >> (23 - F + d)). Guard = first dropped bit, sticky = OR of remaining dropped bits; ties go to even.
  - If (23-F+d) >= 25, mag = 0.
  - Saturation: mag > 2^(ELEM_WIDTH-1)-1 clamps to 2^(ELEM_WIDTH-1)-1 (symmetric; most negative code never produced).
  - element = s ? -mag : mag.
- Scale is not bumped on rounding overflow; saturation applies instead.
- The conversion datapath is combinational from the buffer read. No extra pipeline stage.

Optional Feature:
MXINT_SAT_FLAG_EN:
- Defined: adds output port o_saturated (1 bit). It is high on any beat whose magnitude was clamped, and reset value is 0.
- Not defined: the port and its logic are absent; conversion behaviour is identical.

Test Plan:
- 32 x 0x3F800000 (1.0), ELEM_WIDTH=8 -> o_scale=127, all elements 0x40, o_last only on beat 31.
- elem0=0x40000000 (2.0), rest 1.0 -> o_scale=128, elem0=0x40, others 0x20.
- elem0=0x3FFFFFFF, elem1=0xBFFFFFFF, rest 0 -> o_scale=127, elem0=0x7F, elem1=0x81, rest 0x00; o_saturated=1 on beats 0,1 with the macro defined.
- RNE with max_exp=127: 0x3F810000 -> 0x40 (64.5 to even); 0x3F830000 -> 0x42 (65.5 up).
- elem5=0x7FC00000 (NaN) -> o_scale=0xFF, all 32 elements 0x00.
- Stall and reset:
  - Drop i_ready for 3 cycles at beat 10 -> outputs stable, no beat lost.
  - Assert i_rst after 7 inputs -> next cycle o_in_ready=1, o_valid=0; a following block of 1.0 yields scale 127 and 0x40 elements.
